fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 105 ++++++++++
 tb/tb_fetch_queue.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues sequential fetch addresses to an instruction
// memory with one cycle of read latency, captures the returned words into a
// small circular buffer, and presents the oldest entry to the core. A redirect
// flushes everything, including a fetch still in the memory pipeline.
//
// Handshake: deq_valid/deq_ready follow strict valid/ready semantics. An entry
// is transferred on a rising edge where both are 1. deq_valid never depends on
// deq_ready, and once raised it stays up with the same payload until the
// transfer, except that a redirect or reset withdraws it.
module fetch_queue #(
  parameter int                     WORD_LEN = 32,
  parameter int                     DEPTH    = 4,
  parameter logic [WORD_LEN-1:0]    RESET_PC = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output logic [WORD_LEN-1:0]         addr_i,
  input  logic [WORD_LEN-1:0]         inst,
  input  logic                        redirect,
  input  logic [WORD_LEN-1:0]         redirect_pc,
  input  logic                        deq_ready,
  output logic                        deq_valid,
  output logic [WORD_LEN-1:0]         deq_inst,
  output logic [WORD_LEN-1:0]         deq_pc,
  output logic [$clog2(DEPTH+1)-1:0]  count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WORD_LEN-1:0] fpc;
  logic [WORD_LEN-1:0] flight_pc;
  logic                inflight;
  logic [PW-1:0]       head;
  logic [PW-1:0]       tail;
  logic [CW-1:0]       count_q;

  logic [WORD_LEN-1:0] inst_mem [DEPTH];
  logic [WORD_LEN-1:0] pc_mem   [DEPTH];

  logic                pop;
  logic                push;
  logic                issue;
  logic [CW:0]         occupancy;

  // Handshake and flow-control decisions for the current cycle.
  // occupancy counts held entries plus the one in the memory pipeline, minus
  // the one leaving now; issuing only while it is below DEPTH reserves a slot
  // for every outstanding fetch, so a returning word is never dropped.
  always_comb begin
    deq_valid = (count_q != '0) & ~redirect;
    pop       = deq_valid & deq_ready;
    push      = inflight & ~redirect;
    occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
    issue     = ~redirect & (occupancy < (CW+1)'(DEPTH));
  end

  assign addr_i   = fpc;
  assign count    = count_q;
  assign deq_inst = inst_mem[head];
  assign deq_pc   = pc_mem[head];

  // Fetch PC, in-flight tracking, pointers and occupancy; redirect wins over all.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpc       <= RESET_PC;
      flight_pc <= '0;
      inflight  <= 1'b0;
      head      <= '0;
      tail      <= '0;
      count_q   <= '0;
    end else if (redirect) begin
      fpc      <= {redirect_pc[WORD_LEN-1:2], 2'b00};
      inflight <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count_q  <= '0;
    end else begin
      if (issue) begin
        fpc       <= fpc + WORD_LEN'(4);
        flight_pc <= fpc;
        inflight  <= 1'b1;
      end else begin
        inflight <= 1'b0;
      end
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage: written at the tail when the in-flight word lands; no reset
  // needed because entries are only read while counted as valid.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[tail] <= inst;
      pc_mem[tail]   <= flight_pc;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a one-cycle-latency memory model, a
// queue-based reference of the fetch stream, directed scenarios and a random
// phase with back-pressure and redirects.
module tb_fetch_queue;

  localparam int          W     = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0;
  localparam logic [31:0] KEY   = 32'hA5A5A5A5;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  addr_i;
  logic [W-1:0]  inst = '0;
  logic          redirect = 1'b0;
  logic [W-1:0]  redirect_pc = '0;
  logic          deq_ready = 1'b0;
  logic          deq_valid;
  logic [W-1:0]  deq_inst;
  logic [W-1:0]  deq_pc;
  logic [2:0]    count;

  always #5 clk = ~clk;

  fetch_queue #(.WORD_LEN(W), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n), .addr_i(addr_i), .inst(inst),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .deq_ready(deq_ready), .deq_valid(deq_valid),
    .deq_inst(deq_inst), .deq_pc(deq_pc), .count(count)
  );

  // Instruction memory: word for an address appears one cycle later.
  always @(posedge clk) inst <= addr_i ^ KEY;

  // ---------------- scoreboard / reference ----------------
  // exp_q holds the pcs of entries the queue should hold, oldest first.
  logic [W-1:0] exp_q[$];
  logic         m_flight;
  logic [W-1:0] m_flight_pc;
  logic [W-1:0] m_fpc;
  int           n_cmp = 0;
  int           n_err = 0;
  int           n_pop = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_model();
    logic exp_valid;
    exp_valid = (exp_q.size() != 0) && !redirect;
    check("count", W'(count), W'(exp_q.size()));
    check("deq_valid", W'(deq_valid), W'(exp_valid));
    check("addr_i", addr_i, m_fpc);
    if (exp_valid && deq_valid) begin
      check("deq_pc", deq_pc, exp_q[0]);
      check("deq_inst", deq_inst, exp_q[0] ^ KEY);
    end
  endtask

  // One clock cycle: present inputs, advance the reference by the stream
  // rules, then compare just after the edge.
  task automatic step(input logic rd, input logic [W-1:0] rpc, input logic rdy);
    logic m_pop;
    int   occ;
    redirect    = rd;
    redirect_pc = rpc;
    deq_ready   = rdy;
    m_pop = (exp_q.size() != 0) && !rd && rdy;
    occ   = int'(exp_q.size()) + int'(m_flight) - int'(m_pop);
    if (rd) begin
      exp_q.delete();
      m_flight = 1'b0;
      m_fpc    = rpc & ~32'h3;
    end else begin
      if (m_pop) begin
        void'(exp_q.pop_front());
        n_pop++;
      end
      if (m_flight) exp_q.push_back(m_flight_pc);
      if (occ < DEPTH) begin
        m_flight    = 1'b1;
        m_flight_pc = m_fpc;
        m_fpc       = m_fpc + 32'd4;
      end else begin
        m_flight = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check_model();
  endtask

  // Asynchronous reset: effects must be visible without a clock edge.
  task automatic do_reset();
    rst_n     = 1'b0;
    redirect  = 1'b0;
    deq_ready = 1'b0;
    #1;
    exp_q.delete();
    m_flight = 1'b0;
    m_fpc    = RPC;
    check("rst_count", W'(count), 32'd0);
    check("rst_valid", W'(deq_valid), 32'd0);
    check("rst_addr", addr_i, RPC);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_addr", addr_i, RPC);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    m_flight    = 1'b0;
    m_flight_pc = '0;
    m_fpc       = RPC;
    @(posedge clk);
    #1;
    do_reset();

    // Streaming with the core always ready: first entry two cycles after release.
    step(0, 0, 1);
    step(0, 0, 1);
    check("first_valid", W'(deq_valid), 32'd1);
    check("first_pc", deq_pc, RPC);
    n_pop = 0;
    repeat (20) step(0, 0, 1);
    check("throughput", W'(n_pop), 32'd20);

    // Back-pressure: queue fills and fetching stalls.
    do_reset();
    repeat (10) step(0, 0, 0);
    check("fill_count", W'(count), 32'd4);
    check("fill_addr", addr_i, 32'h10);
    repeat (10) step(0, 0, 1);

    // Redirect with three entries held and one fetch in flight.
    do_reset();
    repeat (4) step(0, 0, 0);
    check("pre_redir_count", W'(count), 32'd3);
    step(1, 32'h103, 0);
    check("redir_count", W'(count), 32'd0);
    check("redir_addr", addr_i, 32'h100);
    step(0, 0, 1);
    step(0, 0, 1);
    check("redir_first_valid", W'(deq_valid), 32'd1);
    check("redir_first_pc", deq_pc, 32'h100);
    repeat (6) step(0, 0, 1);

    // Redirect coinciding with deq_ready at count=2: no pop.
    do_reset();
    repeat (3) step(0, 0, 0);
    check("pre_r2_count", W'(count), 32'd2);
    n_pop = 0;
    step(1, 32'h200, 1);
    check("r2_nopop", W'(n_pop), 32'd0);
    check("r2_addr", addr_i, 32'h200);
    repeat (6) step(0, 0, 1);

    // Back-to-back redirects: the last one wins.
    step(1, 32'h300, 1);
    step(1, 32'h405, 1);
    check("b2b_addr", addr_i, 32'h404);
    repeat (6) step(0, 0, 1);

    // Full queue drained and refilled across many wraps.
    do_reset();
    repeat (6) step(0, 0, 0);
    for (int i = 0; i < 40; i++) step(0, 0, ($urandom_range(0, 3) != 0));

    // Reset pulsed mid-stream at count=3.
    do_reset();
    repeat (4) step(0, 0, 0);
    check("pre_rst_count", W'(count), 32'd3);
    do_reset();
    step(0, 0, 1);
    step(0, 0, 1);
    check("restart_pc", deq_pc, RPC);
    repeat (4) step(0, 0, 1);

    // Random traffic: back-pressure and occasional redirects to random targets.
    for (int i = 0; i < 400; i++) begin
      logic rd;
      rd = ($urandom_range(0, 15) == 0);
      step(rd, $urandom, ($urandom_range(0, 3) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
